if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage driving the IF/ID pipeline register. It holds the fetch PC and runs a req/ack handshake with instruction memory, which may have variable latency. Fetched {PC, instruction} pairs go into a 2-entry buffer, and the head of that buffer is presented to IF/ID. The stage handles hazard-unit stalls and EX-stage redirects, including discarding a memory response that is still in flight.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_IFID  in  1  clock, shared with IF/ID
- rst_IFID  in  1  reset, asynchronous, active-high
- stall_IF  in  1  hazard unit: IF/ID must hold this cycle
- redirect_valid  in  1  taken branch/jump from EX
- redirect_pc  in  32  redirect target
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  response valid; sampled at posedge while imem_req=1
- imem_rdata  in  32  instruction, valid in ack cycle
- pc_out_IF  out  32  to PC_in_IFID
- inst_out_IF  out  32  to inst_in_IFID
- en_out_IF  out  1  to en_IFID
- valid_out_IF  out  1  pc/inst come from buffer head, not a bubble

## Operation
- States: IDLE (reset only), REQ (normal fetch), DRAIN (one stale response still owed).
- IDLE → REQ on the first clock after reset releases.
- In REQ, imem_req = (count<2); imem_addr = fetch_pc.
  - Ack: push {fetch_pc, imem_rdata}; fetch_pc += 4.
- Once imem_req is asserted it is never withdrawn before ack. count only rises via ack, so count<2 holds through the whole wait.
- Output side:
  - Buffer non-empty: pc/inst = head; valid_out=1.
  - Buffer empty: inst = NOP 32'h0000_0013, pc = 0, valid_out=0.
  - en_out_IF = ~stall_IF | redirect_valid.
  - Pop the head at posedge when ~stall_IF and not empty.
- Redirect, which has priority over stall and ack:
  - Flush the buffer (count=0).
  - Force bubble outputs (NOP, valid_out=0, en_out_IF=1) in the same cycle.
  - fetch_pc <= redirect_pc.
  - If a request is outstanding and not acked this cycle, go to DRAIN.
  - If acked this cycle, discard the data and stay in REQ.
- DRAIN:
  - imem_req stays 1 with the old address.
  - On ack, discard the data and return to REQ.
  - A further redirect in DRAIN only updates fetch_pc.
- Simultaneous push and pop leaves count unchanged. A push with count==2 cannot occur; assert on it in simulation.
- PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - pc_out_IF=0, inst_out_IF=NOP, valid_out_IF=0
  - en_out_IF follows ~stall_IF
  - count=0, state IDLE
- First imem_req goes high 1 cycle after rst_IFID deasserts.
- Ack to IF/ID input: 1 cycle (buffered). IF/ID captures one edge later.
- Throughput with a zero-wait memory (ack in the same cycle as req) and no stall: 1 instruction/cycle at steady state with count=1.
- Stall: the head is held stable. Fetch continues until count=2, then imem_req=0 until a pop.
- Reset mid-request: all state clears immediately. The memory must tolerate an abandoned request.

## Structure
- Shared cpu_pkg holds:
  - NOP_INST = 32'h0000_0013
  - default RESET_PC
  - fetch state enum {IDLE, REQ, DRAIN}
- Sub-module fetch_buffer: 2-entry FIFO of 64-bit {pc, inst} with push, pop, flush, count, and head ports.

## Test plan
- Reset release, zero-wait memory, no stall → imem_addr 0,4,8,…; pc_out_IF 0,4,8 on consecutive cycles starting 2 cycles after reset.
- 3-cycle memory latency → imem_addr stable for 3 cycles; valid_out_IF high for 1 of every 3 cycles, with a NOP bubble in between.
- stall_IF high for 5 cycles with a zero-wait memory → head held; count reaches 2 and imem_req drops. After release, the sequence resumes with no lost or duplicated PC.
- Redirect to 0x100 while a 3-cycle request for 0x20 is pending → DRAIN; the 0x20 data is discarded; the next imem_addr is 0x100 and the next valid pc_out_IF is 0x100.
- Redirect coincident with ack, and redirect coincident with stall → bubble with en_out_IF=1; the buffer is emptied and fetch restarts at the target.
- rst_IFID pulsed mid-request → outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, reset PC, fetch FSM states and the
// {pc, inst} entry carried from fetch into IF/ID.
package cpu_pkg;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, inst} pairs; flush wins over push and pop.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         clk_IFID,
  input  logic         rst_IFID,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic         rd_ptr, wr_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk_IFID or posedge rst_IFID) begin
    if (rst_IFID) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_IFID) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
      if (!rst_IFID) assert (count != 2'd2);
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, req/ack to imem, 2-deep buffer feeding IF/ID, and
// redirect handling that drains a stale in-flight response.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_IFID,
  input  logic        rst_IFID,
  input  logic        stall_IF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out_IF,
  output logic [31:0] inst_out_IF,
  output logic        en_out_IF,
  output logic        valid_out_IF
);
  fetch_state_t state;
  logic [31:0]  fetch_pc, drain_addr;
  logic [1:0]   count;
  fetch_entry_t head, din;
  logic         push, pop, show;

  // count only rises on ack, so a raised request stays up until answered.
  assign imem_req  = ((state == REQ) && (count < 2'd2)) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;

  assign push = (state == REQ) && imem_req && imem_ack && !redirect_valid;
  assign pop  = !stall_IF && (count != 2'd0) && !redirect_valid;
  assign din  = '{pc: fetch_pc, inst: imem_rdata};

  fetch_buffer u_buf (
    .clk_IFID (clk_IFID),
    .rst_IFID (rst_IFID),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .din      (din),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk_IFID or posedge rst_IFID) begin
    if (rst_IFID) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect_valid) fetch_pc <= redirect_pc;
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            // Unanswered request: its response is still owed and must be dropped.
            if (imem_req && !imem_ack) begin
              state      <= DRAIN;
              drain_addr <= fetch_pc;
            end
          end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        DRAIN: begin
          if (redirect_valid) fetch_pc <= redirect_pc;
          if (imem_ack)       state    <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign show         = (count != 2'd0) && !redirect_valid;
  assign valid_out_IF = show;
  assign pc_out_IF    = show ? head.pc   : 32'h0;
  assign inst_out_IF  = show ? head.inst : NOP_INST;
  assign en_out_IF    = ~stall_IF | redirect_valid;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; a queue scoreboard checks every pair IF/ID accepts.
module tb_if_fetch_stage;
  logic        clk_IFID = 1'b0;
  logic        rst_IFID;
  logic        stall_IF, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_out_IF, inst_out_IF;
  logic        en_out_IF, valid_out_IF;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] sb_exp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_stage dut (
    .clk_IFID       (clk_IFID),
    .rst_IFID       (rst_IFID),
    .stall_IF       (stall_IF),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_out_IF      (pc_out_IF),
    .inst_out_IF    (inst_out_IF),
    .en_out_IF      (en_out_IF),
    .valid_out_IF   (valid_out_IF)
  );

  always #5 clk_IFID = ~clk_IFID;

  // Memory model: ack after mem_lat cycles of request, at most mem_budget acks per reset.
  int mem_lat    = 1;
  int mem_budget = 0;
  int wait_cnt, ack_cnt;
  assign imem_ack   = imem_req && (ack_cnt < mem_budget) && (wait_cnt >= mem_lat - 1);
  assign imem_rdata = ~imem_addr;

  always @(posedge clk_IFID or posedge rst_IFID) begin
    if (rst_IFID) begin
      wait_cnt <= 0;
      ack_cnt  <= 0;
    end else if (imem_ack) begin
      wait_cnt <= 0;
      ack_cnt  <= ack_cnt + 1;
    end else if (imem_req) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Monitor: a pair is taken by IF/ID when valid and enabled at the coming edge.
  always @(negedge clk_IFID) begin
    if (!rst_IFID && valid_out_IF && en_out_IF) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got pc %h, want no output", pc_out_IF);
      end else begin
        sb_exp = exp_q.pop_front();
        if (pc_out_IF !== sb_exp || inst_out_IF !== ~sb_exp) begin
          n_fail++;
          $display("FAIL sb_pair: got pc %h inst %h, want pc %h inst %h",
                   pc_out_IF, inst_out_IF, sb_exp, ~sb_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_IFID);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Leaves the bench at posedge+1 with reset just released; next edge is E1.
  task automatic do_reset(input int lat, input int budget);
    rst_IFID = 1'b1;
    stall_IF = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    exp_q.delete();
    mem_lat = lat;
    mem_budget = budget;
    step(2);
    rst_IFID = 1'b0;
  endtask

  initial begin
    rst_IFID = 1'b1;
    stall_IF = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    step(2);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc_out_IF, 32'h0);
    chk("rst_inst", inst_out_IF, NOP);
    chk("rst_valid", valid_out_IF, 0);
    chk("rst_en", en_out_IF, 1);
    stall_IF = 1'b1;
    #1 chk("rst_en_stall", en_out_IF, 0);

    // Zero-wait streaming
    do_reset(1, 6);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    #1 chk("zw_idle_req", imem_req, 0);
    step(1);
    chk("zw_e1_req", imem_req, 1);
    chk("zw_e1_addr", imem_addr, 32'h0);
    step(1);
    chk("zw_e2_valid", valid_out_IF, 1);
    chk("zw_e2_pc", pc_out_IF, 32'h0);
    chk("zw_e2_addr", imem_addr, 32'h4);
    chk("zw_e2_en", en_out_IF, 1);
    step(1);
    chk("zw_e3_pc", pc_out_IF, 32'h4);
    chk("zw_e3_addr", imem_addr, 32'h8);
    step(1);
    chk("zw_e4_pc", pc_out_IF, 32'h8);
    step(10);
    chk("zw_drain", exp_q.size(), 0);

    // 3-cycle latency
    do_reset(3, 3);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    step(1); chk("l3_e1_addr", imem_addr, 32'h0); chk("l3_e1_req", imem_req, 1);
    step(1); chk("l3_e2_addr", imem_addr, 32'h0);
    step(1); chk("l3_e3_addr", imem_addr, 32'h0); chk("l3_e3_valid", valid_out_IF, 0);
    step(1); chk("l3_e4_valid", valid_out_IF, 1); chk("l3_e4_pc", pc_out_IF, 32'h0);
    chk("l3_e4_addr", imem_addr, 32'h4);
    step(1); chk("l3_e5_valid", valid_out_IF, 0); chk("l3_e5_inst", inst_out_IF, NOP);
    step(1); chk("l3_e6_valid", valid_out_IF, 0);
    step(1); chk("l3_e7_valid", valid_out_IF, 1); chk("l3_e7_pc", pc_out_IF, 32'h4);
    step(8);
    chk("l3_drain", exp_q.size(), 0);

    // Stall for 5 cycles with zero-wait memory
    do_reset(1, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    step(2);
    stall_IF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("st_head_pc", pc_out_IF, 32'h0);
      chk("st_head_valid", valid_out_IF, 1);
      chk("st_req_low", imem_req, 0);
    end
    stall_IF = 1'b0;
    step(15);
    chk("st_drain", exp_q.size(), 0);

    // Redirect with ack, then redirect while a 3-cycle fetch of 0x20 is pending
    do_reset(1, 5);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    #1;
    chk("rda_valid", valid_out_IF, 0);
    chk("rda_inst", inst_out_IF, NOP);
    chk("rda_pc", pc_out_IF, 32'h0);
    chk("rda_en", en_out_IF, 1);
    step(1);
    redirect_valid = 1'b0; mem_lat = 3;
    #1 chk("rda_addr", imem_addr, 32'h20);
    step(1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    #1;
    chk("drn_req", imem_req, 1);
    chk("drn_addr", imem_addr, 32'h20);
    step(1);
    chk("drn_next_addr", imem_addr, 32'h100);
    chk("drn_no_stale", valid_out_IF, 0);
    step(3);
    chk("drn_valid", valid_out_IF, 1);
    chk("drn_pc", pc_out_IF, 32'h100);
    step(12);
    chk("drn_drain", exp_q.size(), 0);

    // Redirect while stalled with a full buffer
    do_reset(1, 5);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    step(2);
    stall_IF = 1'b1;
    step(1);
    chk("rds_full_req", imem_req, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("rds_valid", valid_out_IF, 0);
    chk("rds_inst", inst_out_IF, NOP);
    chk("rds_en", en_out_IF, 1);
    step(1);
    redirect_valid = 1'b0; stall_IF = 1'b0;
    #1;
    chk("rds_addr", imem_addr, 32'h40);
    chk("rds_empty", valid_out_IF, 0);
    step(12);
    chk("rds_drain", exp_q.size(), 0);

    // Reset pulsed mid-request
    do_reset(3, 1);
    exp_q.push_back(32'h0);
    step(4);
    chk("mr_valid", valid_out_IF, 1);
    chk("mr_pc", pc_out_IF, 32'h0);
    step(1);
    chk("mr_pend_req", imem_req, 1);
    chk("mr_pend_addr", imem_addr, 32'h4);
    rst_IFID = 1'b1;
    #1;
    chk("mr_rst_req", imem_req, 0);
    chk("mr_rst_addr", imem_addr, 32'h0);
    chk("mr_rst_valid", valid_out_IF, 0);
    chk("mr_rst_inst", inst_out_IF, NOP);
    exp_q.push_back(32'h0);
    step(2);
    rst_IFID = 1'b0;
    step(1);
    chk("mr_re_req", imem_req, 1);
    chk("mr_re_addr", imem_addr, 32'h0);
    step(3);
    chk("mr_re_pc", pc_out_IF, 32'h0);
    step(6);
    chk("mr_drain", exp_q.size(), 0);

    // PC wrap at 2^32
    do_reset(1, 4);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    step(1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    #1 chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step(1);
    chk("wr_wrap_addr", imem_addr, 32'h0);
    chk("wr_pc", pc_out_IF, 32'hFFFF_FFFC);
    step(8);
    chk("wr_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
